// File: rtl/vesa_ca_pkg.sv
// Shared constants and types for the image RAM and the requesters around it.
package vesa_ca_pkg;

    localparam int RAM_AW       = 10;
    localparam int RAM_DW       = 16;
    localparam int RAM_DEPTH    = 1 << RAM_AW;
    localparam int MAX_WAIT_DEF = 4;

    // Owner of an in-flight port-A read, one bit per reader: {disp, gen}.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_GEN  = 2'b01,
        OWNER_DISP = 2'b10
    } owner_t;

endpackage

// File: rtl/image_ram_arbiter_if.sv
// Requester handshakes, tagged read return and RAM drive of the image RAM arbiter.
interface image_ram_arbiter_if
    import vesa_ca_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
);

    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          gen_rreq;
    logic [AW-1:0] gen_raddr;
    logic          gen_rgnt;
    logic          gen_wreq;
    logic [AW-1:0] gen_waddr;
    logic [DW-1:0] gen_wdata;
    logic          gen_wgnt;
    logic          rst_wreq;
    logic [AW-1:0] rst_waddr;
    logic [DW-1:0] rst_wdata;
    logic          rst_wgnt;
    logic          disp_rvalid;
    logic          gen_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_ena;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_douta;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dinb;
    logic          stat_clr;
    logic [15:0]   gen_stall_cnt;

    modport slave (
        input  disp_req, disp_addr, gen_rreq, gen_raddr,
        input  gen_wreq, gen_waddr, gen_wdata, rst_wreq, rst_waddr, rst_wdata,
        input  ram_douta, stat_clr,
        output disp_gnt, gen_rgnt, gen_wgnt, rst_wgnt,
        output disp_rvalid, gen_rvalid, rdata,
        output ram_ena, ram_addra, ram_enb, ram_addrb, ram_dinb,
        output gen_stall_cnt
    );

    modport master (
        output disp_req, disp_addr, gen_rreq, gen_raddr,
        output gen_wreq, gen_waddr, gen_wdata, rst_wreq, rst_waddr, rst_wdata,
        output ram_douta, stat_clr,
        input  disp_gnt, gen_rgnt, gen_wgnt, rst_wgnt,
        input  disp_rvalid, gen_rvalid, rdata,
        input  ram_ena, ram_addra, ram_enb, ram_addrb, ram_dinb,
        input  gen_stall_cnt
    );

endinterface

// File: rtl/port_b_arbiter.sv
// Port-B write arbitration: generator normally wins, but a reset writer that has
// lost MAX_WAIT cycles in a row is given the port for one cycle.
module port_b_arbiter
    import vesa_ca_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gen_wreq,
    input  logic rst_wreq,
    output logic gen_wgnt,
    output logic rst_wgnt
);

    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    logic [2:0] wait_cnt;
    logic       starved;

    assign starved = (wait_cnt == WAIT_LIMIT);

    // Pick the port-B winner; nothing is granted while in reset.
    always_comb begin
        gen_wgnt = 1'b0;
        rst_wgnt = 1'b0;
        if (rst_n) begin
            if (rst_wreq && (starved || !gen_wreq)) begin
                rst_wgnt = 1'b1;
            end else if (gen_wreq) begin
                gen_wgnt = 1'b1;
            end
        end
    end

    // Count consecutive losses of a pending reset write, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 3'd0;
        end else if (!rst_wreq || rst_wgnt) begin
            wait_cnt <= 3'd0;
        end else if (!starved) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/image_ram_arbiter.sv
// Shares the dual-port image RAM between display, CA generator and CA reset writer.
// Port A serves reads (display first), port B serves writes; read data comes back
// one cycle later with an owner tag, and same-address writes are forwarded.
module image_ram_arbiter
    import vesa_ca_pkg::*;
#(
    parameter int AW       = RAM_AW,
    parameter int DW       = RAM_DW,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    image_ram_arbiter_if.slave  bus
);

    logic          disp_gnt;
    logic          gen_rgnt;
    logic          gen_wgnt;
    logic          rst_wgnt;
    logic          ram_ena;
    logic [AW-1:0] ram_addra;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dinb;
    logic          collision;
    logic          stall;
    owner_t        owner_q;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [15:0]   stall_cnt;

    port_b_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .gen_wreq (bus.gen_wreq),
        .rst_wreq (bus.rst_wreq),
        .gen_wgnt (gen_wgnt),
        .rst_wgnt (rst_wgnt)
    );

    // Port-A grants: the display is never held off, the generator reads in its gaps.
    always_comb begin
        disp_gnt = rst_n & bus.disp_req;
        gen_rgnt = rst_n & bus.gen_rreq & ~bus.disp_req;
    end

    // Drive RAM port A from the granted reader, idle address 0 otherwise.
    always_comb begin
        ram_ena   = disp_gnt | gen_rgnt;
        ram_addra = '0;
        if (disp_gnt) begin
            ram_addra = bus.disp_addr;
        end else if (gen_rgnt) begin
            ram_addra = bus.gen_raddr;
        end
    end

    // Drive RAM port B from the granted writer, idle zeros otherwise.
    always_comb begin
        ram_enb   = gen_wgnt | rst_wgnt;
        ram_addrb = '0;
        ram_dinb  = '0;
        if (gen_wgnt) begin
            ram_addrb = bus.gen_waddr;
            ram_dinb  = bus.gen_wdata;
        end else if (rst_wgnt) begin
            ram_addrb = bus.rst_waddr;
            ram_dinb  = bus.rst_wdata;
        end
    end

    assign collision = ram_ena & ram_enb & (ram_addra == ram_addrb);
    assign stall     = bus.gen_rreq & ~gen_rgnt;

    // Remember who owns the read issued this cycle so its data can be tagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWNER_NONE;
        end else if (disp_gnt) begin
            owner_q <= OWNER_DISP;
        end else if (gen_rgnt) begin
            owner_q <= OWNER_GEN;
        end else begin
            owner_q <= OWNER_NONE;
        end
    end

    // Capture same-cycle write data so a colliding read returns the new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit <= collision;
            if (collision) begin
                fwd_data <= ram_dinb;
            end
        end
    end

    // Saturating count of generator read stalls; a clear overrides a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (bus.stat_clr) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.disp_gnt      = disp_gnt;
    assign bus.gen_rgnt      = gen_rgnt;
    assign bus.gen_wgnt      = gen_wgnt;
    assign bus.rst_wgnt      = rst_wgnt;
    assign bus.ram_ena       = ram_ena;
    assign bus.ram_addra     = ram_addra;
    assign bus.ram_enb       = ram_enb;
    assign bus.ram_addrb     = ram_addrb;
    assign bus.ram_dinb      = ram_dinb;
    assign bus.disp_rvalid   = (owner_q == OWNER_DISP);
    assign bus.gen_rvalid    = (owner_q == OWNER_GEN);
    assign bus.rdata         = fwd_hit ? fwd_data : bus.ram_douta;
    assign bus.gen_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: directed scenarios plus a randomized run against
// a rule-level model of grants, memory contents and the stall counter.
module tb_image_ram_arbiter;
    import vesa_ca_pkg::*;

    localparam int AW       = RAM_AW;
    localparam int DW       = RAM_DW;
    localparam int MAX_WAIT = MAX_WAIT_DEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] ram_mem [RAM_DEPTH];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] ref_mem [RAM_DEPTH];

    image_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    image_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 40503) ^ 16'h5A5A;
    endfunction

    // RAM model: falling-edge, registered port-A read (read-first), port-B write.
    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) ram_mem[i] = init_word(i);
        ram_q <= '0;
        forever begin
            @(negedge clk);
            if (bus.ram_ena) ram_q <= ram_mem[bus.ram_addra];
            if (bus.ram_enb) ram_mem[bus.ram_addrb] = bus.ram_dinb;
        end
    end
    assign bus.ram_douta = ram_q;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_inputs();
        bus.disp_req  = 1'b0; bus.disp_addr = '0;
        bus.gen_rreq  = 1'b0; bus.gen_raddr = '0;
        bus.gen_wreq  = 1'b0; bus.gen_waddr = '0; bus.gen_wdata = '0;
        bus.rst_wreq  = 1'b0; bus.rst_waddr = '0; bus.rst_wdata = '0;
        bus.stat_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.disp_req = 1'b1; bus.gen_rreq = 1'b1; bus.gen_wreq = 1'b1; bus.rst_wreq = 1'b1;
        bus.disp_addr = 10'h001; bus.gen_raddr = 10'h002; bus.gen_waddr = 10'h003; bus.rst_waddr = 10'h004;
        repeat (2) @(posedge clk);
        #2;
        n_total++;
        if ({bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt, bus.ram_ena, bus.ram_enb} !== 6'b0)
            $display("[TB] FAIL reset_grants: got %b required 000000",
                     {bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt, bus.ram_ena, bus.ram_enb});
        else n_pass++;
        n_total++;
        if ({bus.disp_rvalid, bus.gen_rvalid, bus.gen_stall_cnt} !== 18'd0)
            $display("[TB] FAIL reset_state: rvalid %b%b cnt %0d required 00 cnt 0",
                     bus.disp_rvalid, bus.gen_rvalid, bus.gen_stall_cnt);
        else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_display_stream();
        for (int i = 0; i <= 256; i++) begin
            @(posedge clk); #1;
            bus.disp_req  = (i < 256);
            bus.disp_addr = AW'(i);
            bus.gen_rreq  = 1'b1;
            bus.gen_raddr = 10'h010;
            #1;
            n_total++;
            if (i < 256) begin
                if ({bus.disp_gnt, bus.gen_rgnt, bus.ram_addra} !== {1'b1, 1'b0, AW'(i)})
                    $display("[TB] FAIL stream_grant %0d: got d%b g%b a%h required d1 g0 a%h",
                             i, bus.disp_gnt, bus.gen_rgnt, bus.ram_addra, AW'(i));
                else n_pass++;
            end else begin
                if ({bus.gen_rgnt, bus.ram_addra} !== {1'b1, 10'h010})
                    $display("[TB] FAIL stream_gen_rise: got g%b a%h required g1 a010",
                             bus.gen_rgnt, bus.ram_addra);
                else n_pass++;
            end
            if (i > 0) begin
                n_total++;
                if ({bus.disp_rvalid, bus.gen_rvalid, bus.rdata} !== {2'b10, ref_mem[i-1]})
                    $display("[TB] FAIL stream_rdata %0d: got v%b%b d%h required v10 d%h",
                             i - 1, bus.disp_rvalid, bus.gen_rvalid, bus.rdata, ref_mem[i-1]);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_total++;
        if ({bus.disp_rvalid, bus.gen_rvalid, bus.rdata} !== {2'b01, ref_mem[16]})
            $display("[TB] FAIL stream_gen_read: got v%b%b d%h required v01 d%h",
                     bus.disp_rvalid, bus.gen_rvalid, bus.rdata, ref_mem[16]);
        else n_pass++;
        n_total++;
        if (bus.gen_stall_cnt !== 16'd256)
            $display("[TB] FAIL stream_stall_cnt: got %0d required 256", bus.gen_stall_cnt);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int            n_gen;
        int            n_rst;
        logic          exp_rst;
        logic [DW-1:0] gdata;
        logic [DW-1:0] rdat;
        n_gen = 0; n_rst = 0;
        gdata = DW'($urandom); rdat = DW'($urandom);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            bus.gen_wreq  = 1'b1; bus.gen_waddr = AW'(10'h100 + n_gen); bus.gen_wdata = gdata;
            bus.rst_wreq  = 1'b1; bus.rst_waddr = AW'(10'h200 + n_rst); bus.rst_wdata = rdat;
            #1;
            exp_rst = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            n_total++;
            if (exp_rst) begin
                if ({bus.gen_wgnt, bus.rst_wgnt, bus.ram_enb, bus.ram_addrb, bus.ram_dinb}
                    !== {3'b011, AW'(10'h200 + n_rst), rdat})
                    $display("[TB] FAIL starve_cycle %0d: got g%b r%b a%h d%h required g0 r1 a%h d%h",
                             k, bus.gen_wgnt, bus.rst_wgnt, bus.ram_addrb, bus.ram_dinb,
                             AW'(10'h200 + n_rst), rdat);
                else n_pass++;
                ref_mem[10'h200 + n_rst] = rdat;
                n_rst++;
                rdat = DW'($urandom);
            end else begin
                if ({bus.gen_wgnt, bus.rst_wgnt, bus.ram_enb, bus.ram_addrb, bus.ram_dinb}
                    !== {3'b101, AW'(10'h100 + n_gen), gdata})
                    $display("[TB] FAIL starve_cycle %0d: got g%b r%b a%h d%h required g1 r0 a%h d%h",
                             k, bus.gen_wgnt, bus.rst_wgnt, bus.ram_addrb, bus.ram_dinb,
                             AW'(10'h100 + n_gen), gdata);
                else n_pass++;
                ref_mem[10'h100 + n_gen] = gdata;
                n_gen++;
                gdata = DW'($urandom);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_forwarding();
        logic [DW-1:0] d;
        d = DW'($urandom);
        @(posedge clk); #1;
        bus.gen_wreq = 1'b1; bus.gen_waddr = 10'h020; bus.gen_wdata = 16'hBEEF;
        bus.disp_req = 1'b1; bus.disp_addr = 10'h020;
        #1;
        n_total++;
        if ({bus.disp_gnt, bus.gen_wgnt} !== 2'b11)
            $display("[TB] FAIL fwd_grants: got d%b w%b required d1 w1", bus.disp_gnt, bus.gen_wgnt);
        else n_pass++;
        ref_mem[10'h020] = 16'hBEEF;
        @(posedge clk); #1;
        bus.gen_wreq = 1'b0;
        #1;
        n_total++;
        if ({bus.disp_rvalid, bus.rdata} !== {1'b1, 16'hBEEF})
            $display("[TB] FAIL fwd_collision: got v%b d%h required v1 dbeef", bus.disp_rvalid, bus.rdata);
        else n_pass++;
        @(posedge clk); #1;
        bus.disp_req = 1'b0;
        bus.rst_wreq = 1'b1; bus.rst_waddr = 10'h030; bus.rst_wdata = d;
        bus.gen_rreq = 1'b1; bus.gen_raddr = 10'h030;
        #1;
        n_total++;
        if ({bus.disp_rvalid, bus.rdata} !== {1'b1, 16'hBEEF})
            $display("[TB] FAIL fwd_ram_reread: got v%b d%h required v1 dbeef", bus.disp_rvalid, bus.rdata);
        else n_pass++;
        n_total++;
        if ({bus.rst_wgnt, bus.gen_rgnt} !== 2'b11)
            $display("[TB] FAIL fwd_rst_grants: got r%b g%b required r1 g1", bus.rst_wgnt, bus.gen_rgnt);
        else n_pass++;
        ref_mem[10'h030] = d;
        @(posedge clk); #1;
        idle_inputs();
        bus.disp_req = 1'b1; bus.disp_addr = 10'h031;
        #1;
        n_total++;
        if ({bus.gen_rvalid, bus.rdata} !== {1'b1, d})
            $display("[TB] FAIL fwd_rst_collision: got v%b d%h required v1 d%h", bus.gen_rvalid, bus.rdata, d);
        else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_total++;
        if ({bus.disp_rvalid, bus.rdata} !== {1'b1, ref_mem[10'h031]})
            $display("[TB] FAIL fwd_release: got v%b d%h required v1 d%h",
                     bus.disp_rvalid, bus.rdata, ref_mem[10'h031]);
        else n_pass++;
    endtask

    task automatic test_reset_midread();
        @(posedge clk); #1;
        bus.disp_req = 1'b1; bus.disp_addr = 10'h005;
        bus.gen_rreq = 1'b1; bus.gen_raddr = 10'h006;
        bus.gen_wreq = 1'b1; bus.gen_waddr = 10'h005; bus.gen_wdata = 16'h1357;
        #1;
        n_total++;
        if ({bus.disp_gnt, bus.gen_wgnt} !== 2'b11)
            $display("[TB] FAIL midrst_grant: got d%b w%b required d1 w1", bus.disp_gnt, bus.gen_wgnt);
        else n_pass++;
        ref_mem[10'h005] = 16'h1357;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.rst_wreq = 1'b1; bus.rst_waddr = 10'h007;
        #1;
        n_total++;
        if ({bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt, bus.ram_ena, bus.ram_enb} !== 6'b0)
            $display("[TB] FAIL midrst_forced: got %b required 000000",
                     {bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt, bus.ram_ena, bus.ram_enb});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
        #1;
        n_total++;
        if ({bus.disp_rvalid, bus.gen_rvalid, bus.gen_stall_cnt} !== 18'd0)
            $display("[TB] FAIL midrst_after: rvalid %b%b cnt %0d required 00 cnt 0",
                     bus.disp_rvalid, bus.gen_rvalid, bus.gen_stall_cnt);
        else n_pass++;
    endtask

    task automatic test_stat_clr_saturation();
        @(posedge clk); #1;
        bus.disp_req = 1'b1; bus.disp_addr = 10'h3FF;
        bus.gen_rreq = 1'b1; bus.gen_raddr = 10'h3FE;
        bus.stat_clr = 1'b1;
        @(posedge clk); #1;
        bus.stat_clr = 1'b0;
        #1;
        n_total++;
        if (bus.gen_stall_cnt !== 16'd0)
            $display("[TB] FAIL sat_start: got %0d required 0", bus.gen_stall_cnt);
        else n_pass++;
        repeat (64999) @(posedge clk);
        #2;
        n_total++;
        if (bus.gen_stall_cnt !== 16'd64999)
            $display("[TB] FAIL sat_counting: got %0d required 64999", bus.gen_stall_cnt);
        else n_pass++;
        repeat (5001) @(posedge clk);
        #2;
        n_total++;
        if (bus.gen_stall_cnt !== 16'hFFFF)
            $display("[TB] FAIL sat_ceiling: got %h required ffff", bus.gen_stall_cnt);
        else n_pass++;
        @(posedge clk); #1;
        bus.stat_clr = 1'b1;
        @(posedge clk); #1;
        bus.stat_clr = 1'b0;
        #1;
        n_total++;
        if (bus.gen_stall_cnt !== 16'd0)
            $display("[TB] FAIL sat_clear_wins: got %0d required 0", bus.gen_stall_cnt);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if (bus.gen_stall_cnt !== 16'd1)
            $display("[TB] FAIL sat_recount: got %0d required 1", bus.gen_stall_cnt);
        else n_pass++;
        #(-0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic          d_req, g_rreq, g_wreq, r_wreq, clr;
        logic [AW-1:0] d_addr, g_raddr, g_waddr, r_waddr;
        logic [DW-1:0] g_wdata, r_wdata, exp_data;
        logic          e_dg, e_gr, e_gw, e_rw, exp_dv, exp_gv;
        logic [AW-1:0] e_addra, e_addrb;
        logic [DW-1:0] e_dinb;
        bit            g_rhold, g_whold, r_whold;
        int            losses, model_cnt;
        d_req = 0; g_rreq = 0; g_wreq = 0; r_wreq = 0;
        d_addr = '0; g_raddr = '0; g_waddr = '0; r_waddr = '0; g_wdata = '0; r_wdata = '0;
        g_rhold = 0; g_whold = 0; r_whold = 0;
        losses = 0; model_cnt = 0; exp_dv = 0; exp_gv = 0; exp_data = '0;
        @(posedge clk); #1;
        idle_inputs();
        bus.stat_clr = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            d_req  = ($urandom_range(0, 99) < 40);
            d_addr = AW'($urandom_range(0, 7));
            if (!g_rhold) begin
                g_rreq = ($urandom_range(0, 99) < 50); g_raddr = AW'($urandom_range(0, 7));
            end
            if (!g_whold) begin
                g_wreq = ($urandom_range(0, 99) < 40); g_waddr = AW'($urandom_range(0, 7));
                g_wdata = DW'($urandom);
            end
            if (!r_whold) begin
                r_wreq = ($urandom_range(0, 99) < 50); r_waddr = AW'($urandom_range(0, 7));
                r_wdata = DW'($urandom);
            end
            clr = ($urandom_range(0, 99) < 4);
            bus.disp_req = d_req; bus.disp_addr = d_addr;
            bus.gen_rreq = g_rreq; bus.gen_raddr = g_raddr;
            bus.gen_wreq = g_wreq; bus.gen_waddr = g_waddr; bus.gen_wdata = g_wdata;
            bus.rst_wreq = r_wreq; bus.rst_waddr = r_waddr; bus.rst_wdata = r_wdata;
            bus.stat_clr = clr;
            #1;
            e_dg = d_req;
            e_gr = g_rreq && !d_req;
            e_rw = r_wreq && (!g_wreq || losses >= MAX_WAIT);
            e_gw = g_wreq && !e_rw;
            e_addra = e_dg ? d_addr : (e_gr ? g_raddr : '0);
            e_addrb = e_gw ? g_waddr : (e_rw ? r_waddr : '0);
            e_dinb  = e_gw ? g_wdata : (e_rw ? r_wdata : '0);
            n_total++;
            if ({bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt} !== {e_dg, e_gr, e_gw, e_rw})
                $display("[TB] FAIL rand_grants %0d: got %b required %b", c,
                         {bus.disp_gnt, bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt}, {e_dg, e_gr, e_gw, e_rw});
            else n_pass++;
            n_total++;
            if ({bus.ram_ena, bus.ram_addra, bus.ram_enb, bus.ram_addrb, bus.ram_dinb}
                !== {e_dg | e_gr, e_addra, e_gw | e_rw, e_addrb, e_dinb})
                $display("[TB] FAIL rand_ram_drive %0d: got ea%b a%h eb%b b%h d%h required ea%b a%h eb%b b%h d%h",
                         c, bus.ram_ena, bus.ram_addra, bus.ram_enb, bus.ram_addrb, bus.ram_dinb,
                         e_dg | e_gr, e_addra, e_gw | e_rw, e_addrb, e_dinb);
            else n_pass++;
            n_total++;
            if ({bus.disp_rvalid, bus.gen_rvalid} !== {exp_dv, exp_gv})
                $display("[TB] FAIL rand_rvalid %0d: got %b%b required %b%b", c,
                         bus.disp_rvalid, bus.gen_rvalid, exp_dv, exp_gv);
            else n_pass++;
            if (exp_dv || exp_gv) begin
                n_total++;
                if (bus.rdata !== exp_data)
                    $display("[TB] FAIL rand_rdata %0d: got %h required %h", c, bus.rdata, exp_data);
                else n_pass++;
            end
            if (c > 0) begin
                n_total++;
                if (bus.gen_stall_cnt !== 16'(model_cnt))
                    $display("[TB] FAIL rand_stall_cnt %0d: got %0d required %0d", c, bus.gen_stall_cnt, model_cnt);
                else n_pass++;
            end
            if (e_gw) ref_mem[g_waddr] = g_wdata;
            if (e_rw) ref_mem[r_waddr] = r_wdata;
            exp_dv = e_dg;
            exp_gv = e_gr;
            if (e_dg) exp_data = ref_mem[d_addr];
            else if (e_gr) exp_data = ref_mem[g_raddr];
            if (clr) model_cnt = 0;
            else if (g_rreq && !e_gr && model_cnt < 65535) model_cnt++;
            if (r_wreq && !e_rw) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
            else losses = 0;
            g_rhold = g_rreq && !e_gr;
            g_whold = g_wreq && !e_gw;
            r_whold = r_wreq && !e_rw;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = init_word(i);
        $display("[TB] image_ram_arbiter bench start");
        test_reset();
        test_display_stream();
        test_starvation();
        test_forwarding();
        test_reset_midread();
        test_stat_clr_saturation();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
